// File: rtl/jt12_explin.sv
// Three-stage log-to-linear converter: exponent ROM read, hidden-bit barrel shift,
// then sign application. A channel tag travels alongside each sample.
module jt12_explin #(
    parameter int AW = 8,
    parameter int OW = 10,
    parameter int SW = 4,
    parameter int TW = 3
) (
    input  logic              rst_n,
    input  logic              clk,
    input  logic              cen,
    input  logic              in_valid,
    input  logic [AW+SW-1:0]  in_atten,
    input  logic              in_sign,
    input  logic [TW-1:0]     in_tag,
    output logic              out_valid,
    output logic [OW+1:0]     out_lin,
    output logic [TW-1:0]     out_tag
);
    localparam int DEPTH = 1 << AW;

    function automatic logic [63:0] isqrt(input logic [63:0] n_in);
        logic [63:0] n, res, b;
        n   = n_in;
        res = '0;
        b   = 64'd1 << 62;
        for (int k = 0; k < 32; k++) begin
            if (n >= res + b) begin
                n   = n - (res + b);
                res = (res >> 1) + b;
            end else begin
                res = res >> 1;
            end
            b = b >> 2;
        end
        return res;
    endfunction

    // Q30 fixed point: r walks 2^(1/2), 2^(1/4), ... by repeated square roots and
    // the set bits of the exponent pick which roots multiply into the result.
    function automatic logic [OW-1:0] exp_entry(input int i);
        logic [63:0] acc, r, ent;
        int          e;
        e   = DEPTH - 1 - i;
        acc = 64'd1 << 30;
        r   = 64'd2 << 30;
        for (int m = 1; m <= AW; m++) begin
            r = isqrt(r << 30);
            if (e[AW-m]) acc = (acc * r) >> 30;
        end
        ent = ((acc - (64'd1 << 30)) * (64'd1 << OW) + (64'd1 << 29)) >> 30;
        return ent[OW-1:0];
    endfunction

    logic [OW-1:0] tbl [DEPTH];
    for (genvar g = 0; g < DEPTH; g++) begin : g_tbl
        localparam logic [OW-1:0] ENT = exp_entry(g);
        assign tbl[g] = ENT;
    end

    logic [3:1]    vld_pipe_q;
    logic [OW-1:0] ent_q;
    logic [SW-1:0] sh1_q;
    logic          sg1_q, sg2_q, z2_q;
    logic [TW-1:0] tag1_q, tag2_q, tag3_q;
    logic [OW:0]   mag2_q, mag_d;
    logic [OW+1:0] lin_q, lin_d;

    always_comb begin
        mag_d = {1'b1, ent_q} >> sh1_q;
        if (int'(sh1_q) >= OW + 1) mag_d = '0;
    end

    // Zero magnitude never takes the negate path, so there is no negative zero.
    always_comb begin
        lin_d = {1'b0, mag2_q};
        if (sg2_q && !z2_q) lin_d = -{1'b0, mag2_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe_q <= '0;
            ent_q      <= '0;
            sh1_q      <= '0;
            sg1_q      <= 1'b0;
            tag1_q     <= '0;
            mag2_q     <= '0;
            z2_q       <= 1'b0;
            sg2_q      <= 1'b0;
            tag2_q     <= '0;
            lin_q      <= '0;
            tag3_q     <= '0;
        end else if (cen) begin
            vld_pipe_q <= {vld_pipe_q[2:1], in_valid};
            ent_q      <= tbl[in_atten[AW-1:0]];
            sh1_q      <= in_atten[AW+SW-1:AW];
            sg1_q      <= in_sign;
            tag1_q     <= in_tag;
            mag2_q     <= mag_d;
            z2_q       <= (mag_d == '0);
            sg2_q      <= sg1_q;
            tag2_q     <= tag1_q;
            lin_q      <= lin_d;
            tag3_q     <= tag2_q;
        end
    end

    assign out_valid = vld_pipe_q[3];
    assign out_lin   = lin_q;
    assign out_tag   = tag3_q;
endmodule
